// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM slice: ALU operation codes,
// load/store opcodes and the layout of the control word carried down the pipe.
package ex_mem_stage_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_ADDU = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_SUBU = 5'd3,
        ALU_AND  = 5'd4,
        ALU_OR   = 5'd5,
        ALU_XOR  = 5'd6,
        ALU_NOR  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9,
        ALU_SLL  = 5'd10,
        ALU_SRL  = 5'd11,
        ALU_SRA  = 5'd12,
        ALU_LUI  = 5'd13
    } alu_op_e;

    // Memory opcodes (instruction bits 31:26)
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Control word, MSB first: bit 6 memWr ... bit 0 j
    typedef struct packed {
        logic memWr;
        logic branch;
        logic memToReg;
        logic regWr;
        logic jr;
        logic jal;
        logic j;
    } ex_ctrl_t;

    // alu_cfg bit positions
    localparam int CFG_EXTOP  = 2;
    localparam int CFG_ALUSRC = 1;
    localparam int CFG_SHFSRC = 0;

endpackage

// File: rtl/ex_mem_stage_data_mem.sv
// 256-word data memory with big-endian byte lanes. Writes are synchronous,
// reads are combinational; the opcode picks access width and extension.
module ex_mem_stage_data_mem
    import ex_mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        wrEn,
    input  logic [5:0]  opcode,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] mem [256];
    logic [7:0]  wordIdx;
    logic [1:0]  byteOff;
    logic [3:0]  laneEn;
    logic [31:0] wdataLanes;
    logic [31:0] word;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign wordIdx = addr[9:2];
    assign byteOff = addr[1:0];
    assign word    = mem[wordIdx];

    // Lane enables and replicated store data; lane 3 is bits 31:24 (offset 0)
    always_comb begin
        laneEn     = 4'b1111;
        wdataLanes = wdata;
        case (opcode)
            OP_SB: begin
                laneEn     = 4'b1000 >> byteOff;
                wdataLanes = {4{wdata[7:0]}};
            end
            OP_SH: begin
                laneEn     = addr[1] ? 4'b0011 : 4'b1100;
                wdataLanes = {2{wdata[15:0]}};
            end
            OP_SW:   laneEn = 4'b1111;
            default: laneEn = 4'b1111;
        endcase
    end

    // Synchronous byte-lane write
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int i = 0; i < 4; i++) begin
                if (laneEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= wdataLanes[8*i +: 8];
                end
            end
        end
    end

    // Select the addressed byte/halfword out of the word
    always_comb begin
        byteSel = word[31:24];
        case (byteOff)
            2'd0: byteSel = word[31:24];
            2'd1: byteSel = word[23:16];
            2'd2: byteSel = word[15:8];
            2'd3: byteSel = word[7:0];
            default: byteSel = word[31:24];
        endcase
        halfSel = addr[1] ? word[15:0] : word[31:16];
    end

    // Extend the selected lanes according to the load type
    always_comb begin
        rdata = word;
        case (opcode)
            OP_LW:   rdata = word;
            OP_LB:   rdata = {{24{byteSel[7]}}, byteSel};
            OP_LBU:  rdata = {24'd0, byteSel};
            OP_LH:   rdata = {{16{halfSel[15]}}, halfSel};
            OP_LHU:  rdata = {16'd0, halfSel};
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with forwarding, the EX/MEM pipeline register and the data
// memory that is addressed from the registered MEM-side signals.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  ex_ctrl,
    input  logic [2:0]  alu_cfg,
    input  logic [4:0]  alu_op,
    input  logic [4:0]  shamt,
    input  logic        reg_dst,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    input  logic [31:0] pc_new,
    input  logic [31:0] ins,
    input  logic [31:0] bus_a,
    input  logic [31:0] bus_b,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rw_re,
    input  logic        reg_wr_re,
    input  logic [31:0] bus_w,
    input  logic        flush,
    output logic        loadad,
    output logic [6:0]  me_ctrl,
    output logic        me_zero,
    output logic [4:0]  me_rw,
    output logic [4:0]  me_rs,
    output logic [4:0]  me_rt,
    output logic [31:0] me_alu_out,
    output logic [31:0] me_bus_a,
    output logic [31:0] me_bus_b,
    output logic [31:0] me_jpc,
    output logic [31:0] me_bpc,
    output logic [31:0] me_pc_new,
    output logic [31:0] me_ins,
    output logic [31:0] mem_rdata
);

    ex_ctrl_t    meCtrlQ;
    ex_ctrl_t    exCtrl;
    logic        memFwdOk;
    logic        wbFwdOk;
    logic [31:0] fwdA;
    logic [31:0] fwdB;
    logic [31:0] extImm;
    logic [31:0] opB;
    logic [4:0]  shAmt;
    logic [31:0] aluResult;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [4:0]  rw;
    logic [31:0] storeData;

    assign exCtrl  = ex_ctrl_t'(ex_ctrl);
    assign me_ctrl = meCtrlQ;

    // A MEM-stage load has no data yet, so only ALU results forward from MEM
    assign memFwdOk = meCtrlQ.regWr & ~meCtrlQ.memToReg & (me_rw != 5'd0);
    assign wbFwdOk  = reg_wr_re & (rw_re != 5'd0);

    // Operand forwarding, MEM stage has priority over WB
    always_comb begin
        fwdA = bus_a;
        if (memFwdOk && (me_rw == rs)) begin
            fwdA = me_alu_out;
        end else if (wbFwdOk && (rw_re == rs)) begin
            fwdA = bus_w;
        end
        fwdB = bus_b;
        if (memFwdOk && (me_rw == rt)) begin
            fwdB = me_alu_out;
        end else if (wbFwdOk && (rw_re == rt)) begin
            fwdB = bus_w;
        end
    end

    assign extImm = alu_cfg[CFG_EXTOP] ? {{16{imm[15]}}, imm} : {16'd0, imm};
    assign opB    = alu_cfg[CFG_ALUSRC] ? extImm : fwdB;
    assign shAmt  = alu_cfg[CFG_SHFSRC] ? fwdA[4:0] : shamt;

    // ALU; every arithmetic op wraps, no overflow trap
    always_comb begin
        aluResult = 32'd0;
        case (alu_op)
            ALU_ADD,
            ALU_ADDU: aluResult = fwdA + opB;
            ALU_SUB,
            ALU_SUBU: aluResult = fwdA - opB;
            ALU_AND:  aluResult = fwdA & opB;
            ALU_OR:   aluResult = fwdA | opB;
            ALU_XOR:  aluResult = fwdA ^ opB;
            ALU_NOR:  aluResult = ~(fwdA | opB);
            ALU_SLT:  aluResult = ($signed(fwdA) < $signed(opB)) ? 32'd1 : 32'd0;
            ALU_SLTU: aluResult = (fwdA < opB) ? 32'd1 : 32'd0;
            ALU_SLL:  aluResult = opB << shAmt;
            ALU_SRL:  aluResult = opB >> shAmt;
            ALU_SRA:  aluResult = $unsigned($signed(opB) >>> shAmt);
            ALU_LUI:  aluResult = {imm, 16'd0};
            default:  aluResult = 32'd0;
        endcase
    end

    assign bpc = pc_new + {{14{imm[15]}}, imm, 2'b00};
    assign jpc = {pc_new[31:28], target, 2'b00};
    assign rw  = reg_dst ? rd : rt;

    // The consumer of a load one instruction behind must stall a cycle
    assign loadad = meCtrlQ.regWr & meCtrlQ.memToReg & (me_rw != 5'd0)
                  & ((me_rw == rs) | (me_rw == rt));

    // EX/MEM register; control becomes a bubble on flush or load-use stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meCtrlQ    <= '0;
            me_zero    <= 1'b0;
            me_rw      <= 5'd0;
            me_rs      <= 5'd0;
            me_rt      <= 5'd0;
            me_alu_out <= 32'd0;
            me_bus_a   <= 32'd0;
            me_bus_b   <= 32'd0;
            me_jpc     <= 32'd0;
            me_bpc     <= 32'd0;
            me_pc_new  <= 32'd0;
            me_ins     <= 32'd0;
        end else begin
            meCtrlQ    <= (flush || loadad) ? '0 : exCtrl;
            me_zero    <= (aluResult == 32'd0);
            me_rw      <= rw;
            me_rs      <= rs;
            me_rt      <= rt;
            me_alu_out <= aluResult;
            me_bus_a   <= fwdA;
            me_bus_b   <= fwdB;
            me_jpc     <= jpc;
            me_bpc     <= bpc;
            me_pc_new  <= pc_new;
            me_ins     <= ins;
        end
    end

    // A store in MEM may need the value being written back this cycle
    assign storeData = (reg_wr_re && (rw_re == me_rt) && (rw_re != 5'd0)) ? bus_w : me_bus_b;

    ex_mem_stage_data_mem uDataMem (
        .clk    (clk),
        .wrEn   (meCtrlQ.memWr),
        .opcode (me_ins[31:26]),
        .addr   (me_alu_out[9:0]),
        .wdata  (storeData),
        .rdata  (mem_rdata)
    );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: an ALU vector table, then hand-written
// sequences for forwarding, load-use, memory lanes, targets, flush and reset.
module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic [6:0]  ex_ctrl;
    logic [2:0]  alu_cfg;
    logic [4:0]  alu_op;
    logic [4:0]  shamt;
    logic        reg_dst;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] pc_new;
    logic [31:0] ins;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  rw_re;
    logic        reg_wr_re;
    logic [31:0] bus_w;
    logic        flush;
    logic        loadad;
    logic [6:0]  me_ctrl;
    logic        me_zero;
    logic [4:0]  me_rw;
    logic [4:0]  me_rs;
    logic [4:0]  me_rt;
    logic [31:0] me_alu_out;
    logic [31:0] me_bus_a;
    logic [31:0] me_bus_b;
    logic [31:0] me_jpc;
    logic [31:0] me_bpc;
    logic [31:0] me_pc_new;
    logic [31:0] me_ins;
    logic [31:0] mem_rdata;

    int passCount = 0;
    int checkCount = 0;
    logic [31:0] exp_q[$];

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .ex_ctrl(ex_ctrl), .alu_cfg(alu_cfg),
        .alu_op(alu_op), .shamt(shamt), .reg_dst(reg_dst), .imm(imm),
        .target(target), .pc_new(pc_new), .ins(ins), .bus_a(bus_a),
        .bus_b(bus_b), .rs(rs), .rt(rt), .rd(rd), .rw_re(rw_re),
        .reg_wr_re(reg_wr_re), .bus_w(bus_w), .flush(flush), .loadad(loadad),
        .me_ctrl(me_ctrl), .me_zero(me_zero), .me_rw(me_rw), .me_rs(me_rs),
        .me_rt(me_rt), .me_alu_out(me_alu_out), .me_bus_a(me_bus_a),
        .me_bus_b(me_bus_b), .me_jpc(me_jpc), .me_bpc(me_bpc),
        .me_pc_new(me_pc_new), .me_ins(me_ins), .mem_rdata(mem_rdata)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] immV;
        logic [4:0]  sh;
        logic [2:0]  cfg;
        logic        rdst;
        logic [31:0] expOut;
        logic        expZero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [15:0] immV, input logic [4:0] sh, input logic [2:0] cfg,
                                input logic rdst, input logic [31:0] expOut, input logic expZero);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.immV = immV; v.sh = sh; v.cfg = cfg;
        v.rdst = rdst; v.expOut = expOut; v.expZero = expZero;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic clearIn();
        ex_ctrl = 7'd0; alu_cfg = 3'd0; alu_op = 5'd0; shamt = 5'd0; reg_dst = 1'b0;
        imm = 16'd0; target = 26'd0; pc_new = 32'd0; ins = 32'd0; bus_a = 32'd0;
        bus_b = 32'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; rw_re = 5'd0;
        reg_wr_re = 1'b0; bus_w = 32'd0; flush = 1'b0;
    endtask

    // Memory instruction: address = 0 + sext(addr), data on bus_b
    task automatic issueMem(input logic [5:0] opc, input logic [15:0] addr, input logic [31:0] data,
                            input logic [6:0] ctrl, input logic [4:0] rtv);
        ins = {opc, 26'd0}; alu_op = ALU_ADD; alu_cfg = 3'b110; bus_a = 32'd0;
        imm = addr; bus_b = data; ex_ctrl = ctrl; rs = 5'd0; rt = rtv; reg_dst = 1'b0;
        tick();
    endtask

    task automatic chkLoad(input string name);
        logic [31:0] e;
        e = exp_q.pop_front();
        chk(name, mem_rdata, e);
    endtask

    initial begin
        clearIn();
        reset = 1'b0;
        #12;
        chk("reset_me_alu_out", me_alu_out, 32'd0);
        chk("reset_me_ctrl", {25'd0, me_ctrl}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ALU vector table (no forwarding sources active; rs=1 rt=6 rd=7)
        vecs.push_back(mk(ALU_ADD,  32'd5,        32'd7,        16'h0,    5'd0,  3'b000, 1'b1, 32'd12,       1'b0));
        vecs.push_back(mk(ALU_SUB,  32'd7,        32'd7,        16'h0,    5'd0,  3'b000, 1'b0, 32'd0,        1'b1));
        vecs.push_back(mk(ALU_ADDU, 32'hFFFFFFFF, 32'd1,        16'h0,    5'd0,  3'b000, 1'b1, 32'd0,        1'b1));
        vecs.push_back(mk(ALU_SUBU, 32'd0,        32'd1,        16'h0,    5'd0,  3'b000, 1'b0, 32'hFFFFFFFF, 1'b0));
        vecs.push_back(mk(ALU_ADD,  32'h7FFFFFFF, 32'd1,        16'h0,    5'd0,  3'b000, 1'b1, 32'h80000000, 1'b0));
        vecs.push_back(mk(ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 16'h0,    5'd0,  3'b000, 1'b0, 32'h00F000F0, 1'b0));
        vecs.push_back(mk(ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 16'h0,    5'd0,  3'b000, 1'b1, 32'hFFF0FFF0, 1'b0));
        vecs.push_back(mk(ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 16'h0,    5'd0,  3'b000, 1'b0, 32'hFF00FF00, 1'b0));
        vecs.push_back(mk(ALU_NOR,  32'd0,        32'd0,        16'h0,    5'd0,  3'b000, 1'b1, 32'hFFFFFFFF, 1'b0));
        vecs.push_back(mk(ALU_SLT,  32'hFFFFFFFF, 32'd1,        16'h0,    5'd0,  3'b000, 1'b0, 32'd1,        1'b0));
        vecs.push_back(mk(ALU_SLTU, 32'hFFFFFFFF, 32'd1,        16'h0,    5'd0,  3'b000, 1'b1, 32'd0,        1'b1));
        vecs.push_back(mk(ALU_SLL,  32'd0,        32'd1,        16'h0,    5'd4,  3'b000, 1'b0, 32'd16,       1'b0));
        vecs.push_back(mk(ALU_SRL,  32'd0,        32'h80000000, 16'h0,    5'd31, 3'b000, 1'b1, 32'd1,        1'b0));
        vecs.push_back(mk(ALU_SRA,  32'd0,        32'h80000000, 16'h0,    5'd4,  3'b000, 1'b0, 32'hF8000000, 1'b0));
        vecs.push_back(mk(ALU_SLL,  32'd8,        32'd3,        16'h0,    5'd0,  3'b001, 1'b1, 32'h00000300, 1'b0));
        vecs.push_back(mk(ALU_LUI,  32'd5,        32'd7,        16'h1234, 5'd0,  3'b000, 1'b0, 32'h12340000, 1'b0));
        vecs.push_back(mk(5'd20,    32'd5,        32'd7,        16'h0,    5'd0,  3'b000, 1'b1, 32'd0,        1'b1));
        vecs.push_back(mk(ALU_ADD,  32'd10,       32'd99,       16'hFFFF, 5'd0,  3'b110, 1'b0, 32'd9,        1'b0));
        vecs.push_back(mk(ALU_ADD,  32'd0,        32'd99,       16'hFFFF, 5'd0,  3'b010, 1'b1, 32'h0000FFFF, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            clearIn();
            alu_op = vecs[i].op; bus_a = vecs[i].a; bus_b = vecs[i].b; imm = vecs[i].immV;
            shamt = vecs[i].sh; alu_cfg = vecs[i].cfg; reg_dst = vecs[i].rdst;
            rs = 5'd1; rt = 5'd6; rd = 5'd7;
            tick();
            chk($sformatf("vec%0d_alu_out", i), me_alu_out, vecs[i].expOut);
            chk($sformatf("vec%0d_zero", i), {31'd0, me_zero}, {31'd0, vecs[i].expZero});
            chk($sformatf("vec%0d_rw", i), {27'd0, me_rw}, vecs[i].rdst ? 32'd7 : 32'd6);
        end

        // Forwarding: MEM result beats a simultaneous WB match
        clearIn();
        alu_op = ALU_ADD; bus_a = 32'd5; bus_b = 32'd7; ex_ctrl = 7'h08; reg_dst = 1'b1;
        rd = 5'd3; rs = 5'd1; rt = 5'd2;
        tick();
        ex_ctrl = 7'h00; rs = 5'd3; bus_a = 32'd0; bus_b = 32'd1;
        rw_re = 5'd3; reg_wr_re = 1'b1; bus_w = 32'd9;
        tick();
        chk("fwd_mem_rs", me_alu_out, 32'd13);
        // WB-only match on rt
        rs = 5'd1; bus_a = 32'd1; rt = 5'd3; bus_b = 32'd0;
        tick();
        chk("fwd_wb_rt", me_alu_out, 32'd10);
        // Register 0 never forwards
        clearIn();
        alu_op = ALU_ADD; bus_a = 32'd5; bus_b = 32'd7; ex_ctrl = 7'h08; reg_dst = 1'b1; rd = 5'd0;
        tick();
        ex_ctrl = 7'h00; rs = 5'd0; rt = 5'd1; bus_a = 32'd2; bus_b = 32'd1;
        rw_re = 5'd0; reg_wr_re = 1'b1; bus_w = 32'd9;
        tick();
        chk("fwd_r0_none", me_alu_out, 32'd3);

        // Load-use hazard
        clearIn();
        issueMem(OP_LW, 16'd0, 32'd0, 7'h18, 5'd4);
        chk("lu_me_ctrl_load", {25'd0, me_ctrl}, 32'h18);
        ex_ctrl = 7'h08; rs = 5'd5; rt = 5'd6; ins = 32'd0;
        #1;
        chk("lu_no_match", {31'd0, loadad}, 32'd0);
        rs = 5'd4;
        #1;
        chk("lu_rs_match", {31'd0, loadad}, 32'd1);
        tick();
        chk("lu_bubble", {25'd0, me_ctrl}, 32'd0);
        chk("lu_cleared", {31'd0, loadad}, 32'd0);
        clearIn();
        issueMem(OP_LW, 16'd0, 32'd0, 7'h18, 5'd4);
        rs = 5'd0; rt = 5'd4; ex_ctrl = 7'h00;
        #1;
        chk("lu_rt_match", {31'd0, loadad}, 32'd1);
        clearIn();
        issueMem(OP_LW, 16'd0, 32'd0, 7'h18, 5'd0);
        rs = 5'd0; rt = 5'd0; ex_ctrl = 7'h00;
        #1;
        chk("lu_r0_none", {31'd0, loadad}, 32'd0);

        // Stores and sub-word loads
        clearIn();
        issueMem(OP_SW, 16'd8, 32'hDEADBEEF, 7'h40, 5'd7);
        issueMem(OP_LB, 16'd9, 32'd0, 7'h00, 5'd0);  exp_q.push_back(32'hFFFFFFAD); chkLoad("lb_9");
        issueMem(OP_LBU, 16'd9, 32'd0, 7'h00, 5'd0); exp_q.push_back(32'h000000AD); chkLoad("lbu_9");
        issueMem(OP_LHU, 16'd10, 32'd0, 7'h00, 5'd0); exp_q.push_back(32'h0000BEEF); chkLoad("lhu_10");
        issueMem(OP_LH, 16'd8, 32'd0, 7'h00, 5'd0);  exp_q.push_back(32'hFFFFDEAD); chkLoad("lh_8");
        issueMem(OP_LW, 16'd8, 32'd0, 7'h00, 5'd0);  exp_q.push_back(32'hDEADBEEF); chkLoad("lw_8");
        issueMem(OP_SB, 16'd11, 32'h00000011, 7'h40, 5'd7);
        issueMem(OP_LW, 16'd8, 32'd0, 7'h00, 5'd0);  exp_q.push_back(32'hDEADBE11); chkLoad("sb_lanes");
        issueMem(OP_SH, 16'd8, 32'h00002222, 7'h40, 5'd7);
        issueMem(OP_LW, 16'd8, 32'd0, 7'h00, 5'd0);  exp_q.push_back(32'h2222BE11); chkLoad("sh_lanes");
        issueMem(OP_LB, 16'd11, 32'd0, 7'h00, 5'd0); exp_q.push_back(32'h00000011); chkLoad("lb_11");

        // Store data forwarded from WB while the store is in MEM
        issueMem(OP_SW, 16'd12, 32'd0, 7'h40, 5'd9);
        rw_re = 5'd9; reg_wr_re = 1'b1; bus_w = 32'hCAFEF00D;
        issueMem(OP_LW, 16'd12, 32'd0, 7'h00, 5'd0);
        reg_wr_re = 1'b0;
        exp_q.push_back(32'hCAFEF00D); chkLoad("st_fwd");
        issueMem(OP_LW, 16'd13, 32'd0, 7'h00, 5'd0); exp_q.push_back(32'hCAFEF00D); chkLoad("lw_misalign");
        issueMem(OP_LHU, 16'd15, 32'd0, 7'h00, 5'd0); exp_q.push_back(32'h0000F00D); chkLoad("lhu_misalign");

        // Flushed store must not write
        issueMem(OP_SW, 16'd16, 32'h12345678, 7'h40, 5'd7);
        issueMem(OP_LW, 16'd16, 32'd0, 7'h00, 5'd0); exp_q.push_back(32'h12345678); chkLoad("lw_16");
        flush = 1'b1;
        issueMem(OP_SW, 16'd16, 32'h00000055, 7'h40, 5'd7);
        flush = 1'b0;
        chk("flush_bubble", {25'd0, me_ctrl}, 32'd0);
        issueMem(OP_LW, 16'd16, 32'd0, 7'h00, 5'd0); exp_q.push_back(32'h12345678); chkLoad("flush_no_write");

        // Branch and jump targets
        clearIn();
        pc_new = 32'h00400004; imm = 16'hFFFF; target = 26'h0100000;
        tick();
        chk("bpc_back", me_bpc, 32'h00400000);
        chk("jpc_a", me_jpc, 32'h00400000);
        chk("pc_new_pass", me_pc_new, 32'h00400004);
        pc_new = 32'h10000000; imm = 16'h0004; target = 26'h3FFFFFF;
        tick();
        chk("bpc_fwd", me_bpc, 32'h10000010);
        chk("jpc_b", me_jpc, 32'h1FFFFFFC);

        // Asynchronous reset in the middle of the cycle
        clearIn();
        alu_op = ALU_ADD; bus_a = 32'd5; bus_b = 32'd7; ex_ctrl = 7'h7F; reg_dst = 1'b1; rd = 5'd3;
        rs = 5'd1; rt = 5'd2; pc_new = 32'h00400004; ins = 32'h8C000000; imm = 16'h0010;
        tick();
        chk("pre_reset_out", me_alu_out, 32'd12);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_ctrl", {25'd0, me_ctrl}, 32'd0);
        chk("areset_alu", me_alu_out, 32'd0);
        chk("areset_regs", {17'd0, me_rw, me_rs, me_rt}, 32'd0);
        chk("areset_bus", me_bus_a | me_bus_b, 32'd0);
        chk("areset_pcs", me_pc_new | me_bpc | me_jpc | me_ins, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
